// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and selectable standard or FWFT read mode.
module syn_fifo_flags #(
    parameter int DEPTH    = 64,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 8,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
            $error("syn_fifo_flags: DEPTH must be a power of 2 and >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : gAfCheck
            $error("syn_fifo_flags: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : gAeCheck
            $error("syn_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, underflow_q;
    logic             fullFlag, emptyFlag;
    logic             wrOk, rdOk;

    // Same low bits with opposite wrap bits means the writer is a full lap ahead.
    assign emptyFlag = (wptr_q == rptr_q);
    assign fullFlag  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    always_comb begin
        wrOk    = we & ~fullFlag;
        rdOk    = re & ~emptyFlag;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wrOk) begin
            wptr_d = wptr_q + CW'(1);
        end
        if (rdOk) begin
            rptr_d = rptr_q + CW'(1);
        end
        if (wrOk && !rdOk) begin
            count_d = count_q + CW'(1);
        end else if (rdOk && !wrOk) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= we & fullFlag;
            underflow_q <= re & emptyFlag;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never readable.
    always_ff @(posedge clk) begin
        if (wrOk) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : gFwft
            assign rdata  = mem[rptr_q[AW-1:0]];
            assign rvalid = ~emptyFlag;
        end else begin : gStd
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    if (rdOk) begin
                        rdata_q <= mem[rptr_q[AW-1:0]];
                    end
                    rvalid_q <= rdOk;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    assign full         = fullFlag;
    assign empty        = emptyFlag;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Directed bench for syn_fifo_flags: a standard-mode and an FWFT instance
// (DEPTH=8, AF_LEVEL=6, AE_LEVEL=1) driven with hand-computed vectors.
module tb_syn_fifo_flags;

    logic       clk;
    logic       rst;

    logic       we0, re0;
    logic [7:0] wdata0, rdata0;
    logic       rvalid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic [3:0] count0;

    logic       we1, re1;
    logic [7:0] wdata1, rdata1;
    logic       rvalid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] count1;

    int assertCount;
    int failCount;

    syn_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dutStd (
        .clk(clk), .rst(rst), .we(we0), .wdata(wdata0), .re(re0),
        .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    syn_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dutFwft (
        .clk(clk), .rst(rst), .we(we1), .wdata(wdata1), .re(re1),
        .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic weV, input logic reV, input logic [7:0] wdataV);
        we0    = weV;
        re0    = reV;
        wdata0 = wdataV;
        stepClock();
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        we0 = 1'b0; re0 = 1'b0; wdata0 = '0;
        we1 = 1'b0; re1 = 1'b0; wdata1 = '0;
        stepClock();
        stepClock();
        rst = 1'b0;

        checkOutput("rst_count",  32'(count0),  32'd0);
        checkOutput("rst_empty",  32'(empty0),  32'd1);
        checkOutput("rst_ae",     32'(ae0),     32'd1);
        checkOutput("rst_full",   32'(full0),   32'd0);
        checkOutput("rst_af",     32'(af0),     32'd0);
        checkOutput("rst_rvalid", 32'(rvalid0), 32'd0);
        checkOutput("rst_rdata",  32'(rdata0),  32'd0);
        checkOutput("rst_ovf",    32'(ovf0),    32'd0);
        checkOutput("rst_udf",    32'(udf0),    32'd0);

        // Fill 0x01..0x08, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            checkOutput("fill_count", 32'(count0), 32'(i));
            checkOutput("fill_ae",    32'(ae0),    (i <= 1) ? 32'd1 : 32'd0);
            checkOutput("fill_af",    32'(af0),    (i >= 6) ? 32'd1 : 32'd0);
            checkOutput("fill_full",  32'(full0),  (i == 8) ? 32'd1 : 32'd0);
            checkOutput("fill_empty", 32'(empty0), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("ovf_pulse", 32'(ovf0),   32'd1);
        checkOutput("ovf_count", 32'(count0), 32'd8);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ovf_clear", 32'(ovf0),   32'd0);
        checkOutput("ovf_hold",  32'(count0), 32'd8);

        // Drain 8 words, then one rejected read
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("drain_rdata",  32'(rdata0),  32'(i));
            checkOutput("drain_rvalid", 32'(rvalid0), 32'd1);
            checkOutput("drain_count",  32'(count0),  32'(8 - i));
            checkOutput("drain_empty",  32'(empty0),  (i == 8) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("udf_pulse",  32'(udf0),    32'd1);
        checkOutput("udf_rvalid", 32'(rvalid0), 32'd0);
        checkOutput("udf_rdata",  32'(rdata0),  32'h08);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("udf_clear",  32'(udf0),    32'd0);

        // Wrap-around with occupancy held at 3
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h20 + i));
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h23 + k));
            checkOutput("wrap_rdata", 32'(rdata0), 32'(8'h20 + k));
            checkOutput("wrap_count", 32'(count0), 32'd3);
            checkOutput("wrap_full",  32'(full0),  32'd0);
            checkOutput("wrap_empty", 32'(empty0), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("wrap_tail", 32'(rdata0), 32'(8'h34 + i));
        end
        checkOutput("wrap_done_empty", 32'(empty0), 32'd1);

        // Simultaneous we+re while full, then while empty
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        end
        checkOutput("sim_full", 32'(full0), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkOutput("simf_rdata", 32'(rdata0), 32'h40);
        checkOutput("simf_ovf",   32'(ovf0),   32'd1);
        checkOutput("simf_count", 32'(count0), 32'd7);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("simf_drain", 32'(rdata0), 32'(8'h40 + i));
        end
        checkOutput("simf_empty", 32'(empty0), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h55);
        checkOutput("sime_udf",    32'(udf0),    32'd1);
        checkOutput("sime_count",  32'(count0),  32'd1);
        checkOutput("sime_rvalid", 32'(rvalid0), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("sime_rdata",  32'(rdata0),  32'h55);
        checkOutput("sime_final",  32'(count0),  32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // FWFT instance
        checkOutput("fwft_rst_empty",  32'(empty1),  32'd1);
        checkOutput("fwft_rst_rvalid", 32'(rvalid1), 32'd0);
        we1 = 1'b1; wdata1 = 8'hA5;
        stepClock();
        we1 = 1'b0;
        checkOutput("fwft_empty",  32'(empty1),  32'd0);
        checkOutput("fwft_rvalid", 32'(rvalid1), 32'd1);
        checkOutput("fwft_rdata",  32'(rdata1),  32'hA5);
        checkOutput("fwft_count",  32'(count1),  32'd1);
        stepClock();
        checkOutput("fwft_hold",   32'(rdata1),  32'hA5);
        re1 = 1'b1;
        stepClock();
        re1 = 1'b0;
        checkOutput("fwft_pop_empty",  32'(empty1),  32'd1);
        checkOutput("fwft_pop_rvalid", 32'(rvalid1), 32'd0);

        // Asynchronous reset with five words queued and rvalid high
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h60 + i));
        end
        applyStimulus(1'b1, 1'b1, 8'h65);
        checkOutput("pre_rst_count",  32'(count0),  32'd5);
        checkOutput("pre_rst_rvalid", 32'(rvalid0), 32'd1);
        we0 = 1'b0; re0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_count",  32'(count0),  32'd0);
        checkOutput("arst_empty",  32'(empty0),  32'd1);
        checkOutput("arst_rvalid", 32'(rvalid0), 32'd0);
        checkOutput("arst_ovf",    32'(ovf0),    32'd0);
        checkOutput("arst_udf",    32'(udf0),    32'd0);
        checkOutput("arst_full",   32'(full0),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        stepClock();
        applyStimulus(1'b1, 1'b0, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("post_rst_rdata",  32'(rdata0),  32'h11);
        checkOutput("post_rst_rvalid", 32'(rvalid0), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
